// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings, device timing and the
// field layout of the 25-bit logical address used by the SDRAM blocks.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP        = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [3:0] CMD_READ       = 4'b0101;
    localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
    localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [3:0] CMD_AREF       = 4'b0001;
    localparam logic [3:0] CMD_MREG       = 4'b0000;

    localparam int T_RCD   = 2;
    localparam int T_RP    = 2;
    localparam int CAS_LAT = 3;

    localparam int BA_MSB  = 24;
    localparam int BA_LSB  = 23;
    localparam int ROW_MSB = 22;
    localparam int ROW_LSB = 11;
    localparam int COL_MSB = 8;
    localparam int COL_LSB = 0;

    localparam logic [1:0]  BA_IDLE      = 2'b11;
    localparam logic [11:0] ADDR_IDLE    = 12'hFFF;
    localparam logic [11:0] ADDR_PRE_ALL = 12'h400;

    // A requested length of zero still moves one word.
    function automatic logic [7:0] eff_blength(input logic [7:0] bl);
        return (bl == 8'd0) ? 8'd1 : bl;
    endfunction

endpackage

// File: rtl/sdram_read_ctrl.sv
// Single-transaction SDRAM read: ACTIVE, READ, BURST STOP, PRECHARGE, with
// registered command/address outputs and a captured, strobed data burst.
module sdram_read_ctrl #(
    parameter int T_RCD   = sdram_pkg::T_RCD,
    parameter int CAS_LAT = sdram_pkg::CAS_LAT,
    parameter int T_RP    = sdram_pkg::T_RP
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        init_end,
    input  logic        rd_en,
    input  logic [24:0] rd_addri,
    input  logic [15:0] rd_din,
    input  logic [7:0]  rd_blength,
    output logic        rd_valid,
    output logic        rd_end,
    output logic [3:0]  rd_cmdo,
    output logic [1:0]  rd_bao,
    output logic [11:0] rd_addro,
    output logic [15:0] rd_datao
);
    import sdram_pkg::*;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACTIVE,
        S_TRCD,
        S_READ,
        S_CL,
        S_DATA,
        S_PRE,
        S_TRP,
        S_END
    } state_t;

    localparam logic [9:0] CNT_TRCD_LAST = 10'(T_RCD - 1);
    localparam logic [9:0] CNT_TRP_LAST  = 10'(T_RP - 1);
    localparam logic [9:0] CNT_CAS       = 10'(CAS_LAT);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_cnt;
    logic [9:0]  w_cnt_nxt;
    logic [1:0]  r_ba;
    logic [11:0] r_row;
    logic [8:0]  r_col;
    logic [7:0]  r_blen;

    logic [3:0]  r_cmd;
    logic [1:0]  r_bao;
    logic [11:0] r_addro;
    logic        r_valid;
    logic        r_end;
    logic [15:0] r_datao;

    logic [3:0]  w_cmd_nxt;
    logic [1:0]  w_bao_nxt;
    logic [11:0] w_addro_nxt;
    logic        w_valid_nxt;
    logic        w_end_nxt;
    logic [15:0] w_datao_nxt;

    logic        w_start;
    logic [9:0]  w_blen_ext;
    logic [9:0]  w_data_last;
    logic        w_unused;

    assign w_start     = (r_state == S_IDLE) && init_end && rd_en;
    assign w_blen_ext  = {2'b00, r_blen};
    assign w_data_last = CNT_CAS + w_blen_ext;
    assign w_unused    = ^rd_addri[10:9];

    // State and cycle counter register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 10'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request latch, sampled only when a transaction is accepted.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ba   <= 2'b00;
            r_row  <= 12'h000;
            r_col  <= 9'h000;
            r_blen <= 8'd0;
        end else if (w_start) begin
            r_ba   <= rd_addri[BA_MSB:BA_LSB];
            r_row  <= rd_addri[ROW_MSB:ROW_LSB];
            r_col  <= rd_addri[COL_MSB:COL_LSB];
            r_blen <= eff_blength(rd_blength);
        end else begin
            r_ba   <= r_ba;
            r_row  <= r_row;
            r_col  <= r_col;
            r_blen <= r_blen;
        end
    end

    // Next-state logic; in CL/DATA the counter holds cycles elapsed since READ.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_ACTIVE;
                    w_cnt_nxt   = 10'd0;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 10'd0;
                end
            end
            S_ACTIVE: begin
                w_state_nxt = S_TRCD;
                w_cnt_nxt   = 10'd0;
            end
            S_TRCD: begin
                if (r_cnt == CNT_TRCD_LAST) begin
                    w_state_nxt = S_READ;
                    w_cnt_nxt   = 10'd0;
                end else begin
                    w_state_nxt = S_TRCD;
                    w_cnt_nxt   = r_cnt + 10'd1;
                end
            end
            S_READ: begin
                w_state_nxt = S_CL;
                w_cnt_nxt   = 10'd1;
            end
            S_CL: begin
                if (r_cnt == CNT_CAS) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_CL;
                end
                w_cnt_nxt = r_cnt + 10'd1;
            end
            S_DATA: begin
                if (r_cnt == w_data_last) begin
                    w_state_nxt = S_PRE;
                    w_cnt_nxt   = 10'd0;
                end else begin
                    w_state_nxt = S_DATA;
                    w_cnt_nxt   = r_cnt + 10'd1;
                end
            end
            S_PRE: begin
                w_state_nxt = S_TRP;
                w_cnt_nxt   = 10'd0;
            end
            S_TRP: begin
                if (r_cnt == CNT_TRP_LAST) begin
                    w_state_nxt = S_END;
                    w_cnt_nxt   = 10'd0;
                end else begin
                    w_state_nxt = S_TRP;
                    w_cnt_nxt   = r_cnt + 10'd1;
                end
            end
            S_END: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 10'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 10'd0;
            end
        endcase
    end

    // Outputs decoded from the next state so they register into place with it.
    always_comb begin
        w_cmd_nxt   = CMD_NOP;
        w_bao_nxt   = BA_IDLE;
        w_addro_nxt = ADDR_IDLE;
        w_valid_nxt = 1'b0;
        w_end_nxt   = 1'b0;
        w_datao_nxt = 16'h0000;
        case (w_state_nxt)
            S_ACTIVE: begin
                w_cmd_nxt   = CMD_ACTIVE;
                w_bao_nxt   = rd_addri[BA_MSB:BA_LSB];
                w_addro_nxt = rd_addri[ROW_MSB:ROW_LSB];
            end
            S_READ: begin
                w_cmd_nxt   = CMD_READ;
                w_bao_nxt   = r_ba;
                w_addro_nxt = {3'b000, r_col};
            end
            S_CL: begin
                if (w_cnt_nxt == w_blen_ext) begin
                    w_cmd_nxt = CMD_BURST_STOP;
                end else begin
                    w_cmd_nxt = CMD_NOP;
                end
            end
            S_DATA: begin
                if (w_cnt_nxt == w_blen_ext) begin
                    w_cmd_nxt = CMD_BURST_STOP;
                end else begin
                    w_cmd_nxt = CMD_NOP;
                end
                w_valid_nxt = 1'b1;
                w_datao_nxt = rd_din;
            end
            S_PRE: begin
                w_cmd_nxt   = CMD_PRECHARGE;
                w_addro_nxt = ADDR_PRE_ALL;
            end
            S_END: begin
                w_end_nxt = 1'b1;
            end
            default: begin
                w_cmd_nxt = CMD_NOP;
            end
        endcase
    end

    // Registered command, address and data outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cmd   <= CMD_NOP;
            r_bao   <= BA_IDLE;
            r_addro <= ADDR_IDLE;
            r_valid <= 1'b0;
            r_end   <= 1'b0;
            r_datao <= 16'h0000;
        end else begin
            r_cmd   <= w_cmd_nxt;
            r_bao   <= w_bao_nxt;
            r_addro <= w_addro_nxt;
            r_valid <= w_valid_nxt;
            r_end   <= w_end_nxt;
            r_datao <= w_datao_nxt;
        end
    end

    assign rd_cmdo  = r_cmd;
    assign rd_bao   = r_bao;
    assign rd_addro = r_addro;
    assign rd_valid = r_valid;
    assign rd_end   = r_end;
    assign rd_datao = r_datao;

endmodule

// File: tb/tb_sdram_read_ctrl.sv
// Directed bench for sdram_read_ctrl: a cycle-indexed expectation of the
// command/data sequence plus a small DQ memory model driving rd_din.
module tb_sdram_read_ctrl;
    import sdram_pkg::*;

    logic        sys_clk;
    logic        sys_rst;
    logic        init_end;
    logic        rd_en;
    logic [24:0] rd_addri;
    logic [15:0] rd_din;
    logic [7:0]  rd_blength;
    logic        rd_valid;
    logic        rd_end;
    logic [3:0]  rd_cmdo;
    logic [1:0]  rd_bao;
    logic [11:0] rd_addro;
    logic [15:0] rd_datao;

    int n_tests = 0;
    int n_fail  = 0;

    sdram_read_ctrl #(
        .T_RCD   (T_RCD),
        .CAS_LAT (CAS_LAT),
        .T_RP    (T_RP)
    ) u_dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .init_end   (init_end),
        .rd_en      (rd_en),
        .rd_addri   (rd_addri),
        .rd_din     (rd_din),
        .rd_blength (rd_blength),
        .rd_valid   (rd_valid),
        .rd_end     (rd_end),
        .rd_cmdo    (rd_cmdo),
        .rd_bao     (rd_bao),
        .rd_addro   (rd_addro),
        .rd_datao   (rd_datao)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Content of the modelled device at a given location.
    function automatic logic [15:0] mem_word(input logic [1:0] ba, input logic [11:0] row,
                                             input logic [8:0] col);
        return {ba, row[4:0], col};
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cmd"},   32'(rd_cmdo),  32'(CMD_NOP));
        chk({tag, "_ba"},    32'(rd_bao),   32'(2'b11));
        chk({tag, "_addr"},  32'(rd_addro), 32'(12'hFFF));
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_end"},   32'(rd_end),   32'd0);
        chk({tag, "_data"},  32'(rd_datao), 32'd0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk); #1;
            chk_idle_outputs(tag);
        end
    endtask

    // Issues one request; the next clock edge is expected to start ACTIVE (cycle 0).
    task automatic run_txn(input logic [1:0] ba, input logic [11:0] row, input logic [8:0] col,
                           input logic [7:0] bl, input int drop_at, input bit hold_en,
                           input int abort_at);
        int r, eb, p, e;
        logic [3:0] exp_cmd;
        bit in_win;
        r  = T_RCD + 1;
        eb = (bl == 8'd0) ? 1 : int'(bl);
        p  = r + CAS_LAT + eb + 1;
        e  = p + T_RP + 1;
        rd_addri   = {ba, row, 2'b11, col};
        rd_blength = bl;
        rd_en      = 1'b1;
        init_end   = 1'b1;
        for (int c = 0; c <= e; c++) begin
            @(posedge sys_clk); #1;
            if (c == abort_at) begin
                #1 sys_rst = 1'b1;
                #1;
                chk_idle_outputs("rst_mid");
                rd_en = 1'b0;
                @(posedge sys_clk); #1;
                chk_idle_outputs("rst_hold");
                sys_rst = 1'b0;
                return;
            end
            if (c == 0)                exp_cmd = CMD_ACTIVE;
            else if (c == r)           exp_cmd = CMD_READ;
            else if (c == r + eb)      exp_cmd = CMD_BURST_STOP;
            else if (c == p)           exp_cmd = CMD_PRECHARGE;
            else                       exp_cmd = CMD_NOP;
            in_win = (c >= r + CAS_LAT + 1) && (c <= r + CAS_LAT + eb);
            chk("cmd",   32'(rd_cmdo),  32'(exp_cmd));
            chk("end",   32'(rd_end),   32'(c == e));
            chk("valid", 32'(rd_valid), 32'(in_win));
            if (in_win)
                chk("data", 32'(rd_datao), 32'(mem_word(ba, row, 9'(col + 9'(c - r - CAS_LAT - 1)))));
            else
                chk("data0", 32'(rd_datao), 32'd0);
            if (c == 0) begin
                chk("act_ba",   32'(rd_bao),   32'(ba));
                chk("act_addr", 32'(rd_addro), 32'(row));
            end else if (c == r) begin
                chk("rd_ba",   32'(rd_bao),   32'(ba));
                chk("rd_addr", 32'(rd_addro), 32'({3'b000, col}));
            end else if (c == p) begin
                chk("pre_addr", 32'(rd_addro), 32'(12'h400));
            end else begin
                chk("oth_ba",   32'(rd_bao),   32'(2'b11));
                chk("oth_addr", 32'(rd_addro), 32'(12'hFFF));
            end
            if (c == drop_at) rd_en = 1'b0;
            if (c == e && !hold_en) rd_en = 1'b0;
            if (c >= r + CAS_LAT && c < r + CAS_LAT + eb)
                rd_din = mem_word(ba, row, 9'(col + 9'(c - r - CAS_LAT)));
            else
                rd_din = 16'hDEAD;
        end
        @(posedge sys_clk); #1;
        chk_idle_outputs("gap");
    endtask

    initial begin
        sys_rst    = 1'b1;
        init_end   = 1'b0;
        rd_en      = 1'b1;
        rd_addri   = 25'h0000801;
        rd_blength = 8'd8;
        rd_din     = 16'h5A5A;
        #1;
        chk_idle_outputs("rst_async");
        idle_cycles(3, "rst");
        sys_rst = 1'b0;
        idle_cycles(3, "noinit");

        run_txn(2'd0, 12'h001, 9'h001, 8'd8, -1, 1'b0, -1);
        idle_cycles(2, "post_a");
        run_txn(2'd2, 12'h0AB, 9'h010, 8'd1, -1, 1'b0, -1);
        idle_cycles(1, "post_b");
        run_txn(2'd1, 12'h003, 9'h005, 8'd0, -1, 1'b0, -1);
        idle_cycles(1, "post_c");
        run_txn(2'd3, 12'h123, 9'h020, 8'd4, T_RCD + 1 + CAS_LAT + 2, 1'b0, -1);
        idle_cycles(3, "post_drop");
        run_txn(2'd1, 12'h007, 9'h002, 8'd3, -1, 1'b1, -1);
        run_txn(2'd2, 12'h009, 9'h040, 8'd2, -1, 1'b0, -1);
        idle_cycles(1, "post_held");
        run_txn(2'd0, 12'h005, 9'h003, 8'd8, -1, 1'b0, T_RCD + 1 + CAS_LAT + 3);
        idle_cycles(2, "post_rst");
        run_txn(2'd0, 12'h002, 9'h000, 8'd2, -1, 1'b0, -1);
        idle_cycles(2, "final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
